// File: rtl/shift_deser_pkg.sv
// Shared types and sizing helpers for the serial-in/parallel-out receiver.
package shift_deser_pkg;

  typedef logic state_t;

  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_SHIFT = 1'b1;

  localparam int DEF_WIDTH = 8;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

  // Bit-counter width for a given word width; counts 0..width-1.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/shift_deser_out_hold_reg.sv
// Valid/ready output holding register with sticky overrun flag; loads one cycle after word_vld.
// Backpressure: a word arriving while a stalled word is held is dropped and flags overrun.
module shift_deser_out_hold_reg
  import shift_deser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             word_vld,
  input  logic [WIDTH-1:0] word_dat,
  input  logic             out_ready,
  input  logic             clr_overrun,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             overrun
);

  logic can_load;
  logic drop;

  assign can_load = !out_valid || out_ready;
  assign drop     = word_vld && out_valid && !out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (word_vld && can_load) begin
        out_data  <= word_dat;
        out_valid <= 1'b1;
      end else if (!word_vld && out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      // A fresh drop outranks a simultaneous clear.
      if (drop) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/shift_deser.sv
// Serial-in/parallel-out receiver aligned to frame_start; word appears 1 cycle after its last bit.
// Backpressure: single holding register, words completing while it is stalled are dropped (overrun).
module shift_deser
  import shift_deser_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             frame_start,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sync_err,
  output logic             overrun,
  input  logic             clr_overrun
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_base;
  logic [WIDTH-1:0] sreg_nxt;
  logic [CW-1:0]    cnt;
  logic             take_bit;
  logic             word_vld;
  logic             sync_err_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_IDLE && sin_en && frame_start) begin
      state_nxt = ST_SHIFT;
    end
  end

  always_comb begin
    word_vld     = 1'b0;
    sync_err_nxt = 1'b0;
    if (state == ST_SHIFT && sin_en) begin
      if (frame_start) begin
        sync_err_nxt = (cnt != '0);
      end else begin
        word_vld = (cnt == LAST);
      end
    end
  end

  // A frame_start bit begins from an empty register so no stale partial bits leak in.
  always_comb begin
    sreg_base = frame_start ? '0 : sreg;
    if (MSB_FIRST) begin
      sreg_nxt = {sreg_base[WIDTH-2:0], sin};
    end else begin
      sreg_nxt = {sin, sreg_base[WIDTH-1:1]};
    end
  end

  assign take_bit = sin_en && (frame_start || state == ST_SHIFT);

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg     <= '0;
      cnt      <= '0;
      sync_err <= 1'b0;
    end else begin
      sync_err <= sync_err_nxt;
      if (take_bit) begin
        sreg <= sreg_nxt;
        if (frame_start) begin
          cnt <= CW'(1);
        end else if (cnt == LAST) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  shift_deser_out_hold_reg #(
    .WIDTH (WIDTH)
  ) u_out_hold_reg (
    .clk         (clk),
    .rst         (rst),
    .word_vld    (word_vld),
    .word_dat    (sreg_nxt),
    .out_ready   (out_ready),
    .clr_overrun (clr_overrun),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .overrun     (overrun)
  );

endmodule
